// File: rtl/iir_sample_feeder.sv
// iir_sample_feeder: reads a block of signed samples from a synchronous-read memory and streams them
//   to the IIR cascade input one at a time, with a programmable idle gap after each accepted sample.
// Latency: start edge N -> data_in_valid at edge N+2; with in_ready high the sample period is interval+3.
// Backpressure: data_in/addr are held with data_in_valid high until in_ready; no memory read is issued
//   while a sample is waiting to be accepted.
//
// Optional build macro: FEEDER_FLUSH_EN appends FLUSH_LEN zero samples after the last memory sample.
//
// Ports:
//   clk, rst             single rising-edge clock, asynchronous active-high reset
//   start                begins a block; only looked at while idle
//   sample_count         samples per block, latched at start (0 or above 2^ADDR_W means full depth)
//   interval             idle cycles after each transfer, latched at start
//   mem_rd_en/mem_addr   read strobe and address to the sample memory
//   mem_rd_data          memory data, valid the cycle after mem_rd_en
//   data_in/addr         presented sample and its memory index
//   data_in_valid        sample valid; in_ready is the cascade's pipeline enable
//   busy                 high from start acceptance until the feeder is idle again
//   feed_done            one-cycle pulse when the block is complete

module iir_sample_feeder #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 11,
    parameter int FLUSH_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   sample_count,
    input  logic [7:0]        interval,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] data_in,
    output logic              data_in_valid,
    input  logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              feed_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Full memory depth as a sample count (2^ADDR_W), one bit wider than an address.
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;
    logic [7:0]        interval_q, interval_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Index of the final sample of the block being started. Out-of-range
    // counts collapse to the full memory. A count of exactly DEPTH has zero
    // low bits, and the modular subtraction yields the all-ones last index.
    logic [ADDR_W-1:0] start_last_idx;

    always_comb begin
        if ((sample_count == '0) || (sample_count > DEPTH_C)) begin
            start_last_idx = '1;
        end else begin
            start_last_idx = sample_count[ADDR_W-1:0] - 1'b1;
        end
    end

    // After an accepted sample that is not the last, either idle for the
    // programmed gap or go straight to the next fetch.
    state_t after_xfer;

    always_comb begin
        after_xfer = (interval_q != 8'd0) ? S_GAP : S_FETCH;
    end

`ifdef FEEDER_FLUSH_EN
    localparam int FLUSH_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);

    // flush_q marks the zero-sample tail; flush_cnt_q indexes the zero
    // sample currently in flight.
    logic               flush_q, flush_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
`else
    // FLUSH_LEN only shapes the zero-sample tail, which this build omits.
    if (FLUSH_LEN < 0) begin : g_flush_len_unused
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        last_idx_d = last_idx_q;
        interval_d = interval_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        addr_d     = addr_q;
        mem_rd_en  = 1'b0;
`ifdef FEEDER_FLUSH_EN
        flush_d     = flush_q;
        flush_cnt_d = flush_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_idx_d = start_last_idx;
                    interval_d = interval;
                    index_d    = '0;
`ifdef FEEDER_FLUSH_EN
                    flush_d     = 1'b0;
                    flush_cnt_d = '0;
`endif
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
`ifdef FEEDER_FLUSH_EN
                // Zero samples need no memory access.
                mem_rd_en = ~flush_q;
`else
                mem_rd_en = 1'b1;
`endif
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Read data arrives this cycle; capture it so it stays stable
                // for however long the cascade stalls.
`ifdef FEEDER_FLUSH_EN
                data_d = flush_q ? '0 : mem_rd_data;
`else
                data_d = mem_rd_data;
`endif
                addr_d  = index_q;
                state_d = S_PRESENT;
            end

            S_PRESENT: begin
                if (in_ready) begin
                    gap_cnt_d = interval_q;
`ifdef FEEDER_FLUSH_EN
                    if (flush_q) begin
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            flush_cnt_d = flush_cnt_q + 1'b1;
                            state_d     = after_xfer;
                        end
                    end else if (index_q != last_idx_q) begin
                        index_d = index_q + 1'b1;
                        state_d = after_xfer;
                    end else if (FLUSH_LEN > 0) begin
                        // Last memory sample accepted: index stays put so addr
                        // keeps reporting it through the tail.
                        flush_d     = 1'b1;
                        flush_cnt_d = '0;
                        state_d     = after_xfer;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    if (index_q != last_idx_q) begin
                        index_d = index_q + 1'b1;
                        state_d = after_xfer;
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_GAP: begin
                // Entered with gap_cnt_q = interval (>0); leaves after that
                // many cycles.
                if (gap_cnt_q <= 8'd1) begin
                    state_d = S_FETCH;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            last_idx_q <= '0;
            interval_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            last_idx_q <= last_idx_d;
            interval_q <= interval_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
        end
    end

`ifdef FEEDER_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q     <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            flush_q     <= flush_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, so they are glitch-free
    // and return to zero as soon as reset asserts.
    // ------------------------------------------------------------------
    assign mem_addr      = index_q;
    assign data_in       = data_q;
    assign addr          = addr_q;
    assign data_in_valid = (state_q == S_PRESENT);
    assign busy          = (state_q != S_IDLE);
    assign feed_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_iir_sample_feeder.sv
module tb_iir_sample_feeder;

    localparam int DATA_W    = 24;
    localparam int ADDR_W    = 11;
    localparam int FLUSH_LEN = 3;
    localparam int DEPTH     = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   sample_count;
    logic [7:0]        interval;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              feed_done;

    logic [DATA_W-1:0] mem [DEPTH];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
    } xfer_t;

    xfer_t exp_q[$];

    iir_sample_feeder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sample_count(sample_count),
        .interval(interval), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .data_in(data_in), .data_in_valid(data_in_valid),
        .in_ready(in_ready), .addr(addr), .busy(busy), .feed_done(feed_done)
    );

    always #5 clk = ~clk;

    // Edge counter and synchronous-read sample memory.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_valid"}, data_in_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, feed_done, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, data_in, 0);
    endtask

    // Caller is just after a rising edge. mode: 0 ready high, 1 random ready,
    // 2 ready held low for the first 5 valid cycles. mid_start>0 pulses start
    // that many edges into the block; abort_after>0 resets after that transfer.
    task automatic run_block(input int cnt, input int gap, input int mode,
                             input int mid_start, input int abort_after);
        int n, eff, total, n_xfer, n_done, last_t, stall_left, rd_bad, busy_bad;
        int tmo, budget, done_at, exp_rise;
        bit prev_v, finished;
        xfer_t e;

        // Reference: the block is every memory word 0..eff-1 in order,
        // optionally followed by the zero tail tagged with the last index.
        eff = (cnt == 0 || cnt > DEPTH) ? DEPTH : cnt;
        exp_q.delete();
        for (int i = 0; i < eff; i++) exp_q.push_back({mem[i], ADDR_W'(i)});
`ifdef FEEDER_FLUSH_EN
        for (int i = 0; i < FLUSH_LEN; i++) exp_q.push_back({{DATA_W{1'b0}}, ADDR_W'(eff - 1)});
`endif
        total  = exp_q.size();
        budget = total * (gap + 3) * ((mode == 1) ? 8 : 1) + 100;

        sample_count = (ADDR_W+1)'(cnt);
        interval     = 8'(gap);
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = cyc;

        n_xfer = 0; n_done = 0; last_t = -1; rd_bad = 0; busy_bad = 0;
        tmo = 0; done_at = -10; prev_v = 0; finished = 0;
        stall_left = (mode == 2) ? 5 : 0;

        while (!finished) begin
            start = (mid_start > 0 && cyc == n + mid_start);
            if (abort_after > 0 && n_xfer == abort_after) rst = 1'b1;
            case (mode)
                0: in_ready = 1'b1;
                1: in_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (data_in_valid && stall_left > 0) begin
                        in_ready = 1'b0;
                        stall_left--;
                    end else begin
                        in_ready = 1'b1;
                    end
                end
            endcase

            @(negedge clk);
            if (rst) begin
                check_reset_outputs("abort");
                finished = 1;
            end else begin
                if (mem_rd_en && data_in_valid) rd_bad++;
                if (!busy && n_done == 0) busy_bad++;
                if (data_in_valid && !prev_v) begin
                    exp_rise = (n_xfer == 0) ? n + 2 : last_t + gap + 2;
                    check("valid_rise", cyc, exp_rise);
                end
                if (data_in_valid && !in_ready && exp_q.size() > 0) begin
                    check("stall_data", data_in, exp_q[0].d);
                    check("stall_addr", addr, exp_q[0].a);
                end
                if (data_in_valid && in_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_xfer", n_xfer + 1, total);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_data", data_in, e.d);
                        check("xfer_addr", addr, e.a);
                    end
                    n_xfer++;
                    last_t = cyc + 1;
                end
                if (feed_done) begin
                    n_done++;
                    check("done_edge", cyc, last_t);
                    done_at = cyc;
                end
                if (cyc == done_at + 1) begin
                    check("busy_low", busy, 0);
                    finished = 1;
                end
                prev_v = data_in_valid;
                tmo++;
                if (tmo > budget) begin
                    check("timeout", tmo, budget);
                    finished = 1;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;

        if (abort_after > 0) begin
            rst = 1'b0;
            // An abandoned block must not report completion later.
            repeat (10) begin
                @(negedge clk);
                if (feed_done) n_done++;
            end
            @(posedge clk); #1;
            check("abort_xfers", n_xfer, abort_after);
            check("abort_done", n_done, 0);
            check("abort_busy", busy, 0);
        end else begin
            check("xfer_count", n_xfer, total);
            check("done_count", n_done, 1);
            check("exp_left", exp_q.size(), 0);
        end
        check("rd_while_valid", rd_bad, 0);
        check("busy_gap", busy_bad, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; in_ready = 1'b1;
        sample_count = 4; interval = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);

        // Reset held with start and ready asserted: nothing may move.
        repeat (3) begin
            @(negedge clk);
            check("rst_rd_en", mem_rd_en, 0);
        end
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Ramp pattern, back-to-back samples.
        for (int i = 0; i < 4; i++) mem[i] = DATA_W'(i * 'h100);
        run_block(4, 0, 0, 0, 0);

        // Same block with a 5-cycle gap (8-cycle period).
        run_block(4, 5, 0, 0, 0);

        // Most-negative sample stalled for 5 cycles.
        mem[0] = 24'h800000;
        run_block(3, 2, 2, 0, 0);

        // Random contents, lengths, gaps and ready.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 32; i++) mem[i] = DATA_W'($urandom);
            run_block(int'($urandom_range(1, 20)), int'($urandom_range(0, 7)), 1, 0, 0);
        end

        // Two-sample block (zero tail follows when the flush is built in).
        run_block(2, 0, 0, 0, 0);

        // Full-depth blocks: count 0 with a start pulse mid-block, then an
        // oversized count.
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        run_block(0, 0, 0, 1000, 0);
        run_block(3000, 0, 0, 0, 0);

        // Reset after the 2nd transfer, then a fresh block from index 0.
        run_block(6, 1, 0, 0, 2);
        run_block(3, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
